// File: rtl/parc_mem_port_arbiter_if.sv
// Bundle of core I/D request/response ports, the unified memory port and the orphan flag.
// master = arbiter view, slave = core/memory environment view.
interface parc_mem_port_arbiter_if;
    logic [66:0] imemreq_msg;
    logic        imemreq_val;
    logic        imemreq_rdy;
    logic [66:0] dmemreq_msg;
    logic        dmemreq_val;
    logic        dmemreq_rdy;
    logic [34:0] imemresp_msg;
    logic        imemresp_val;
    logic [34:0] dmemresp_msg;
    logic        dmemresp_val;
    logic [66:0] memreq_msg;
    logic        memreq_val;
    logic        memreq_rdy;
    logic [34:0] memresp_msg;
    logic        memresp_val;
    logic        err_orphan_resp;

    modport master (
        input  imemreq_msg, imemreq_val, dmemreq_msg, dmemreq_val,
        output imemreq_rdy, dmemreq_rdy,
        output imemresp_msg, imemresp_val, dmemresp_msg, dmemresp_val,
        output memreq_msg, memreq_val,
        input  memreq_rdy, memresp_msg, memresp_val,
        output err_orphan_resp
    );

    modport slave (
        output imemreq_msg, imemreq_val, dmemreq_msg, dmemreq_val,
        input  imemreq_rdy, dmemreq_rdy,
        input  imemresp_msg, imemresp_val, dmemresp_msg, dmemresp_val,
        input  memreq_msg, memreq_val,
        output memreq_rdy, memresp_msg, memresp_val,
        input  err_orphan_resp
    );
endinterface

// File: rtl/parc_mem_port_arbiter.sv
// Round-robin arbiter merging core I and D memory ports onto one in-order memory port.
// A circular tag FIFO remembers which port issued each outstanding request for response routing.
module parc_mem_port_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    parc_mem_port_arbiter_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic             r_last_d;
    logic             r_err;
    logic [DEPTH-1:0] r_tag;

    logic w_full;
    logic w_grant_i;
    logic w_grant_d;
    logic w_req_val;
    logic w_fire;
    logic w_pop;
    logic w_orphan;
    logic w_head_d;

    assign w_full = (r_count == FULL_CNT);

    // Grant looks only at vals, last grant and full so a stalled request keeps its grant.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (!w_full) begin
            if (bus.imemreq_val && bus.dmemreq_val) begin
                w_grant_i = r_last_d;
                w_grant_d = ~r_last_d;
            end else begin
                w_grant_i = bus.imemreq_val;
                w_grant_d = bus.dmemreq_val;
            end
        end
    end

    // Outputs are forced idle while reset is held low.
    assign w_req_val = (w_grant_i | w_grant_d) & reset;
    assign w_fire    = w_req_val & bus.memreq_rdy;
    assign w_pop     = bus.memresp_val & (r_count != '0) & reset;
    assign w_orphan  = bus.memresp_val & (r_count == '0) & reset;
    assign w_head_d  = r_tag[r_rd_ptr];

    assign bus.memreq_val   = w_req_val;
    assign bus.memreq_msg   = w_grant_d ? bus.dmemreq_msg : bus.imemreq_msg;
    assign bus.imemreq_rdy  = w_grant_i & bus.memreq_rdy & reset;
    assign bus.dmemreq_rdy  = w_grant_d & bus.memreq_rdy & reset;

    assign bus.imemresp_val = w_pop & ~w_head_d;
    assign bus.dmemresp_val = w_pop & w_head_d;
    assign bus.imemresp_msg = bus.memresp_msg;
    assign bus.dmemresp_msg = bus.memresp_msg;
    assign bus.err_orphan_resp = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_last_d <= 1'b1;
            r_err    <= 1'b0;
        end else begin
            if (w_fire) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_last_d <= w_grant_d;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_fire && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_fire && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (w_orphan) begin
                r_err <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read when counted as outstanding.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_tag[r_wr_ptr] <= w_grant_d;
        end
    end
endmodule

// File: tb/tb_parc_mem_port_arbiter.sv
// Bench for the I/D memory port arbiter: directed scenarios with literal expectations,
// then random traffic, all shadowed by a queue-based reference model checked every cycle.
module tb_parc_mem_port_arbiter;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    parc_mem_port_arbiter_if bus ();

    parc_mem_port_arbiter #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.imemreq_val = 1'b0;
        bus.dmemreq_val = 1'b0;
        bus.memresp_val = 1'b0;
    endtask

    // Reference model: outstanding tags as a queue, round-robin pointer as one bit.
    initial begin : model
        bit   q[$];
        bit   m_last_d;
        bit   m_err;
        bit   full, gi, gd, pop, orphan, fire;
        m_last_d = 1'b1;
        m_err    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                m_last_d = 1'b1;
                m_err    = 1'b0;
                chk("rst_memreq_val", bus.memreq_val, 0);
                chk("rst_irdy", bus.imemreq_rdy, 0);
                chk("rst_drdy", bus.dmemreq_rdy, 0);
                chk("rst_iresp_val", bus.imemresp_val, 0);
                chk("rst_dresp_val", bus.dmemresp_val, 0);
                chk("rst_err", bus.err_orphan_resp, 0);
            end else begin
                full = (q.size() == DEPTH);
                gi = 1'b0;
                gd = 1'b0;
                if (!full) begin
                    if (bus.imemreq_val && bus.dmemreq_val) begin
                        if (m_last_d) gi = 1'b1; else gd = 1'b1;
                    end else begin
                        gi = bus.imemreq_val;
                        gd = bus.dmemreq_val;
                    end
                end
                pop    = bus.memresp_val && (q.size() > 0);
                orphan = bus.memresp_val && (q.size() == 0);
                fire   = (gi | gd) & bus.memreq_rdy;
                chk("m_memreq_val", bus.memreq_val, gi | gd);
                if (gi) chk("m_memreq_msg_i", bus.memreq_msg, bus.imemreq_msg);
                if (gd) chk("m_memreq_msg_d", bus.memreq_msg, bus.dmemreq_msg);
                chk("m_irdy", bus.imemreq_rdy, gi & bus.memreq_rdy);
                chk("m_drdy", bus.dmemreq_rdy, gd & bus.memreq_rdy);
                chk("m_iresp_val", bus.imemresp_val, pop && !q[0]);
                chk("m_dresp_val", bus.dmemresp_val, pop && q[0]);
                chk("m_iresp_msg", bus.imemresp_msg, bus.memresp_msg);
                chk("m_dresp_msg", bus.dmemresp_msg, bus.memresp_msg);
                chk("m_err", bus.err_orphan_resp, m_err);
                @(posedge clk);
                if (rst_n) begin
                    if (pop) begin
                        $display("resp %s msg=%0h", q[0] ? "D" : "I", bus.memresp_msg);
                        void'(q.pop_front());
                    end
                    if (orphan) m_err = 1'b1;
                    if (fire) begin
                        q.push_back(gd);
                        m_last_d = gd;
                        $display("req  %s msg=%0h", gd ? "D" : "I", bus.memreq_msg);
                    end
                end
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0;
        bus.imemreq_msg = '0;
        bus.dmemreq_msg = '0;
        bus.memresp_msg = '0;
        bus.memreq_rdy  = 1'b0;
        idle_inputs();

        // Reset holds every val/rdy low even with requests pending.
        tick();
        bus.imemreq_val = 1'b1;
        bus.dmemreq_val = 1'b1;
        bus.memreq_rdy  = 1'b1;
        #3;
        chk("reset_memreq_val", bus.memreq_val, 0);
        chk("reset_irdy", bus.imemreq_rdy, 0);
        tick();
        rst_n = 1'b1;
        idle_inputs();

        // Ties alternate I, D, I, D starting with I.
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.imemreq_val = 1'b1;
            bus.dmemreq_val = 1'b1;
            bus.memreq_rdy  = 1'b1;
            bus.imemreq_msg = 67'h100 + 67'(k);
            bus.dmemreq_msg = 67'h200 + 67'(k);
            #3;
            chk("rr_irdy", bus.imemreq_rdy, (k % 2 == 0));
            chk("rr_drdy", bus.dmemreq_rdy, (k % 2 == 1));
            chk("rr_msg", bus.memreq_msg, (k % 2 == 0) ? 67'h100 + 67'(k) : 67'h200 + 67'(k));
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            idle_inputs();
            bus.memresp_val = 1'b1;
            bus.memresp_msg = 35'h50 + 35'(k);
            #3;
            chk("rr_iresp", bus.imemresp_val, (k % 2 == 0));
            chk("rr_dresp", bus.dmemresp_val, (k % 2 == 1));
            chk("rr_resp_msg", (k % 2 == 0) ? bus.imemresp_msg : bus.dmemresp_msg, 35'h50 + 35'(k));
        end

        // Fill with D requests; a response while full frees a slot only next cycle.
        for (int k = 0; k < 4; k++) begin
            tick();
            idle_inputs();
            bus.dmemreq_val = 1'b1;
            #3;
            chk("fill_drdy", bus.dmemreq_rdy, 1);
        end
        tick();
        #3;
        chk("full_memreq_val", bus.memreq_val, 0);
        chk("full_drdy", bus.dmemreq_rdy, 0);
        tick();
        bus.memresp_val = 1'b1;
        #3;
        chk("full_resp_drdy", bus.dmemreq_rdy, 0);
        chk("full_resp_dval", bus.dmemresp_val, 1);
        tick();
        bus.memresp_val = 1'b0;
        #3;
        chk("after_free_drdy", bus.dmemreq_rdy, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            idle_inputs();
            bus.memresp_val = 1'b1;
            #3;
            chk("drain_dval", bus.dmemresp_val, 1);
        end

        // Stalled I request keeps its grant while D toggles.
        for (int k = 0; k < 3; k++) begin
            tick();
            idle_inputs();
            bus.memreq_rdy  = 1'b0;
            bus.imemreq_val = 1'b1;
            bus.imemreq_msg = 67'h3AB;
            bus.dmemreq_val = (k == 1);
            #3;
            chk("stall_val", bus.memreq_val, 1);
            chk("stall_irdy", bus.imemreq_rdy, 0);
            chk("stall_msg", bus.memreq_msg, 67'h3AB);
        end
        tick();
        bus.dmemreq_val = 1'b1;
        bus.memreq_rdy  = 1'b1;
        #3;
        chk("stall_fire_irdy", bus.imemreq_rdy, 1);
        tick();
        #3;
        chk("post_stall_drdy", bus.dmemreq_rdy, 1);
        for (int k = 0; k < 2; k++) begin
            tick();
            idle_inputs();
            bus.memresp_val = 1'b1;
            #3;
            chk("stall_drain_i", bus.imemresp_val, (k == 0));
        end

        // Simultaneous push/pop with one entry in flight; pointers wrap several times.
        tick();
        idle_inputs();
        bus.imemreq_val = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            bus.imemreq_val = (k % 2 == 0);
            bus.dmemreq_val = (k % 2 == 1);
            bus.memresp_val = 1'b1;
            bus.memresp_msg = 35'h700 + 35'(k);
            #3;
            chk("pp_rdy", bus.imemreq_rdy | bus.dmemreq_rdy, 1);
            chk("pp_dval", bus.dmemresp_val, (k > 0) && ((k - 1) % 2 == 1));
        end
        tick();
        idle_inputs();
        bus.memresp_val = 1'b1;
        #3;
        chk("pp_last_dval", bus.dmemresp_val, 1);

        // Orphan response sets a sticky flag.
        tick();
        #3;
        chk("orphan_ival", bus.imemresp_val, 0);
        chk("orphan_dval", bus.dmemresp_val, 0);
        chk("orphan_err_pre", bus.err_orphan_resp, 0);
        tick();
        bus.memresp_val = 1'b0;
        #3;
        chk("orphan_err", bus.err_orphan_resp, 1);
        tick();
        tick();
        #3;
        chk("orphan_err_sticky", bus.err_orphan_resp, 1);

        // Reset mid-operation drops outstanding tags.
        for (int k = 0; k < 3; k++) begin
            tick();
            bus.imemreq_val = 1'b1;
        end
        tick();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        chk("midrst_err", bus.err_orphan_resp, 0);
        tick();
        rst_n = 1'b1;
        tick();
        bus.memresp_val = 1'b1;
        #3;
        chk("stale_ival", bus.imemresp_val, 0);
        tick();
        bus.memresp_val = 1'b0;
        #3;
        chk("stale_err", bus.err_orphan_resp, 1);
        tick();
        bus.imemreq_val = 1'b1;
        bus.dmemreq_val = 1'b1;
        #3;
        chk("first_tie_irdy", bus.imemreq_rdy, 1);
        chk("first_tie_drdy", bus.dmemreq_rdy, 0);

        // Random traffic, checked by the model alone.
        for (int c = 0; c < 1000; c++) begin
            tick();
            rst_n           = ($urandom_range(0, 199) != 0);
            bus.imemreq_val = 1'($urandom_range(0, 1));
            bus.dmemreq_val = 1'($urandom_range(0, 1));
            bus.memreq_rdy  = ($urandom_range(0, 3) != 0);
            bus.memresp_val = ($urandom_range(0, 2) == 0);
            bus.imemreq_msg = 67'({$urandom(), $urandom(), $urandom()});
            bus.dmemreq_msg = 67'({$urandom(), $urandom(), $urandom()});
            bus.memresp_msg = 35'({$urandom(), $urandom()});
        end
        tick();
        rst_n = 1'b1;
        idle_inputs();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/parc_mem_port_arbiter.md
PARC_MEM_PORT_ARBITER -- requirements
Module: parc_MemPortArbiter

Interface
REQ-001 Parameter: DEPTH, default 4, number of outstanding-request tag entries; power of two, 2..16.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imemreq_msg  input  67  core instruction request, VC_MEM_REQ_MSG_SZ(32,32) packing.
REQ-006 imemreq_val  input  1  instruction request valid.
REQ-007 imemreq_rdy  output  1  instruction request accepted this cycle when high with val.
REQ-008 dmemreq_msg  input  67  core data request, same packing.
REQ-009 dmemreq_val  input  1  data request valid.
REQ-010 dmemreq_rdy  output  1  data request accepted this cycle when high with val.
REQ-011 imemresp_msg  output  35  response to core I-port, VC_MEM_RESP_MSG_SZ(32) packing.
REQ-012 imemresp_val  output  1  I-port response valid; the core always accepts it.
REQ-013 dmemresp_msg  output  35  response to core D-port.
REQ-014 dmemresp_val  output  1  D-port response valid; the core always accepts it.
REQ-015 memreq_msg  output  67  unified memory request.
REQ-016 memreq_val  output  1  unified request valid.
REQ-017 memreq_rdy  input  1  memory accepts the request.
REQ-018 memresp_msg  input  35  unified memory response; responses return in request order.
REQ-019 memresp_val  input  1  unified response valid; no back-pressure exists.
REQ-020 err_orphan_resp  output  1  sticky flag: a response arrived with no outstanding request.

Function
REQ-021 Full flag: full = (count == DEPTH); count is an outstanding-request counter of width log2(DEPTH)+1.
REQ-022 Grant when not full, only one port valid: that port is granted.
REQ-023 Grant when not full, both ports valid: the port opposite to last_grant is granted (round-robin).
REQ-024 Grant when full: nothing is granted.
REQ-025 memreq_val = grant_any; memreq_msg = message of the granted port, passed combinationally with zero latency.
REQ-026 imemreq_rdy = grant_i & memreq_rdy; dmemreq_rdy = grant_d & memreq_rdy; at most one is high in any cycle.
REQ-027 The grant decision depends only on the val inputs, last_grant and full; it never depends on memreq_rdy or memresp_val.
REQ-028 On a fire (memreq_val & memreq_rdy): push the tag (0 = I, 1 = D) into the circular tag FIFO at wr_ptr, increment wr_ptr mod DEPTH, and set last_grant to the granted port.
REQ-029 If a request is presented but not accepted (memreq_rdy low), last_grant does not change; the same port stays granted next cycle provided its val stays high and the full state is unchanged.
REQ-030 On memresp_val with count > 0: route combinationally using the head tag. Tag 0 sets imemresp_val = 1; tag 1 sets dmemresp_val = 1. The routed port's msg = memresp_msg. Then pop: increment rd_ptr mod DEPTH.
REQ-031 The non-selected response port has val = 0; its msg is don't-care but shall be driven as memresp_msg.
REQ-032 Push and pop in the same cycle leave count unchanged; the pointers wrap independently.
REQ-033 A response arriving while full does not unblock a request in the same cycle; the freed entry is usable the next cycle.
REQ-034 Orphan response (memresp_val with count == 0): both core resp_val outputs stay 0, no state changes except err_orphan_resp <= 1, which holds until reset.

Reset
REQ-035 While reset is low: count = 0, wr_ptr = rd_ptr = 0, last_grant = D (so I wins the first tie), err_orphan_resp = 0.
REQ-036 During reset, all val and rdy outputs are 0.
REQ-037 Reset asserted mid-operation discards all outstanding tags; later responses to those requests are treated as orphans (REQ-034).

Verification
REQ-038 Both ports valid for 4 cycles, memreq_rdy = 1, memory responds 2 cycles later -> grants I, D, I, D; responses appear on I, D, I, D ports in order with matching data.
REQ-039 DEPTH = 4, 4 D requests accepted, no responses -> count = 4; memreq_val = 0 and dmemreq_rdy = 0 while full; one response -> request accepted the following cycle, not the same cycle.
REQ-040 I request held with memreq_rdy = 0 for 3 cycles while D toggles valid -> I remains granted, msg stable, last_grant unchanged until the fire.
REQ-041 Push and pop in the same cycle over 20 cycles -> count constant; pointers wrap past DEPTH-1 to 0 with correct routing.
REQ-042 memresp_val pulse with count = 0 -> no resp_val on either port, err_orphan_resp = 1, cleared only by reset.
REQ-043 Reset pulsed low with 3 outstanding requests -> count = 0, err_orphan_resp = 0; the next stale response sets err_orphan_resp; the first tie after reset grants I.
